// File: rtl/phy_bit_sequencer.sv
// phy_bit_sequencer
//   Bit-level sequencer for the I3C SCL/SDA line drivers. Takes START / BIT / STOP
//   requests from the controller FSM and turns them into SCL low/high phases and
//   SDA drive changes. Each BIT returns the sampled SDA level as a one-cycle response.
//   Driver encoding: sel=1 push-pull (data = level); sel=0 open-drain
//   (data=1 pulls low, data=0 releases).
// Ports
//   clk_i, rst_i                          clock, async active-high reset
//   t_low_i, t_high_i, t_hd_i             SCL low/high lengths and SDA hold, in cycles
//   req_valid_i/req_ready_o               request handshake
//   req_op_i, req_bit_i, req_pp_i         00 BIT, 01 START, 10 STOP; bit level; PP select
//   rsp_valid_o, rsp_bit_o                end-of-BIT pulse and sampled SDA
//   err_o, busy_o                         illegal-request pulse; not idle
//   sda_i                                 synchronised SDA level
//   scl_/sda_phy_data_o, *_sel_od_pp_o    line driver controls
module phy_bit_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [CNT_W-1:0] t_low_i,
  input  logic [CNT_W-1:0] t_high_i,
  input  logic [CNT_W-1:0] t_hd_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic             req_bit_i,
  input  logic             req_pp_i,
  output logic             rsp_valid_o,
  output logic             rsp_bit_o,
  output logic             err_o,
  output logic             busy_o,
  input  logic             sda_i,
  output logic             scl_phy_data_o,
  output logic             scl_sel_od_pp_o,
  output logic             sda_phy_data_o,
  output logic             sda_sel_od_pp_o
);
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_START_HD  = 4'd1;
  localparam logic [3:0] S_HOLD      = 4'd2;
  localparam logic [3:0] S_BIT_LOW   = 4'd3;
  localparam logic [3:0] S_BIT_HIGH  = 4'd4;
  localparam logic [3:0] S_RS_LOW    = 4'd5;
  localparam logic [3:0] S_RS_HIGH   = 4'd6;
  localparam logic [3:0] S_STOP_LOW  = 4'd7;
  localparam logic [3:0] S_STOP_HIGH = 4'd8;
  localparam logic [3:0] S_STOP_REL  = 4'd9;

  localparam logic [1:0] OP_BIT   = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d, hd_q, hd_d;
  logic             bit_q, bit_d, pp_q, pp_d;
  logic [1:0]       sda_hold_q, sda_hold_d;   // {data, sel} currently held on SDA
  logic             rsp_valid_q, rsp_valid_d, rsp_bit_q, rsp_bit_d, err_q, err_d;

  logic [CNT_W-1:0] t_low_eff, t_high_eff, hd_clamp;
  logic             last, accept, entry, low_next;
  logic [1:0]       bit_drv;

  assign t_low_eff  = (t_low_i  == '0) ? CNT_W'(1) : t_low_i;
  assign t_high_eff = (t_high_i == '0) ? CNT_W'(1) : t_high_i;
  // SDA must settle before SCL rises, so the hold point is kept inside the low phase.
  assign hd_clamp   = (t_hd_i >= t_low_eff) ? t_low_eff - CNT_W'(1) : t_hd_i;
  assign last       = (cnt_q == len_q - CNT_W'(1));
  assign bit_drv    = pp_q ? {bit_q, 1'b1} : {~bit_q, 1'b0};

  assign req_ready_o = ~rst_i & ((state_q == S_IDLE) | (state_q == S_HOLD));
  assign accept      = req_valid_i & req_ready_o;

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    pp_d       = pp_q;
    sda_hold_d = sda_hold_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        if (req_op_i == OP_START) state_d = S_START_HD;
        else                      err_d   = 1'b1;
      end
      S_START_HD: begin
        sda_hold_d = 2'b10;
        if (last) state_d = S_HOLD;
      end
      S_HOLD: if (accept) begin
        case (req_op_i)
          OP_BIT: begin
            state_d = S_BIT_LOW;
            bit_d   = req_bit_i;
            pp_d    = req_pp_i;
          end
          OP_START: state_d = S_RS_LOW;
          OP_STOP:  state_d = S_STOP_LOW;
          default:  err_d   = 1'b1;
        endcase
      end
      S_BIT_LOW: begin
        if (cnt_q >= hd_q) sda_hold_d = bit_drv;
        if (last) state_d = S_BIT_HIGH;
      end
      S_BIT_HIGH:  if (last) state_d = S_HOLD;
      S_RS_LOW:    if (last) state_d = S_RS_HIGH;
      S_RS_HIGH:   if (last) state_d = S_START_HD;
      S_STOP_LOW:  if (last) state_d = S_STOP_HIGH;
      S_STOP_HIGH: if (last) state_d = S_STOP_REL;
      S_STOP_REL:  if (last) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // No state loops to itself, so any change of state is a fresh entry; the
  // timing inputs are captured only then.
  assign entry    = (state_d != state_q);
  assign low_next = (state_d == S_BIT_LOW) | (state_d == S_RS_LOW) | (state_d == S_STOP_LOW);

  always_comb begin
    cnt_d = cnt_q;
    len_d = len_q;
    hd_d  = hd_q;
    if (entry) begin
      cnt_d = '0;
      len_d = low_next ? t_low_eff : t_high_eff;
      hd_d  = hd_clamp;
    end else if ((state_q != S_IDLE) && (state_q != S_HOLD)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign rsp_valid_d = (state_q == S_BIT_HIGH) & last;
  assign rsp_bit_d   = rsp_valid_d ? sda_i : rsp_bit_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= CNT_W'(1);
      hd_q        <= '0;
      bit_q       <= 1'b0;
      pp_q        <= 1'b0;
      sda_hold_q  <= 2'b00;
      rsp_valid_q <= 1'b0;
      rsp_bit_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      hd_q        <= hd_d;
      bit_q       <= bit_d;
      pp_q        <= pp_d;
      sda_hold_q  <= sda_hold_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_bit_q   <= rsp_bit_d;
      err_q       <= err_d;
    end
  end

  // Line drivers decode straight from the state register so reset releases
  // both lines in the same cycle.
  logic [1:0] scl_o, sda_o;
  always_comb begin
    scl_o = 2'b00;
    sda_o = 2'b00;
    case (state_q)
      S_START_HD:  begin scl_o = 2'b11; sda_o = 2'b10; end
      S_HOLD:      begin scl_o = 2'b01; sda_o = sda_hold_q; end
      S_BIT_LOW:   begin scl_o = 2'b01; sda_o = (cnt_q >= hd_q) ? bit_drv : sda_hold_q; end
      S_BIT_HIGH:  begin scl_o = 2'b11; sda_o = sda_hold_q; end
      S_RS_LOW:    begin scl_o = 2'b01; sda_o = 2'b00; end
      S_RS_HIGH:   begin scl_o = 2'b11; sda_o = 2'b00; end
      S_STOP_LOW:  begin scl_o = 2'b01; sda_o = 2'b10; end
      S_STOP_HIGH: begin scl_o = 2'b11; sda_o = 2'b10; end
      S_STOP_REL:  begin scl_o = 2'b11; sda_o = 2'b00; end
      default:     begin scl_o = 2'b00; sda_o = 2'b00; end
    endcase
  end

  assign {scl_phy_data_o, scl_sel_od_pp_o} = scl_o;
  assign {sda_phy_data_o, sda_sel_od_pp_o} = sda_o;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_bit_o   = rsp_bit_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q != S_IDLE);
endmodule

// File: tb/tb_phy_bit_sequencer.sv
// Testbench for phy_bit_sequencer: directed vector table, a reset-in-bit sequence,
// and random requests checked cycle by cycle against a waveform model.
module tb_phy_bit_sequencer;
  logic       clk_i = 1'b0, rst_i = 1'b1;
  logic [7:0] t_low_i = 8'd4, t_high_i = 8'd3, t_hd_i = 8'd1;
  logic       req_valid_i = 1'b0, req_bit_i = 1'b0, req_pp_i = 1'b0, sda_i = 1'b1;
  logic [1:0] req_op_i = 2'b00;
  logic       req_ready_o, rsp_valid_o, rsp_bit_o, err_o, busy_o;
  logic       scl_phy_data_o, scl_sel_od_pp_o, sda_phy_data_o, sda_sel_od_pp_o;

  phy_bit_sequencer #(.CNT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .t_low_i(t_low_i), .t_high_i(t_high_i), .t_hd_i(t_hd_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_bit_i(req_bit_i), .req_pp_i(req_pp_i), .rsp_valid_o(rsp_valid_o),
    .rsp_bit_o(rsp_bit_o), .err_o(err_o), .busy_o(busy_o), .sda_i(sda_i),
    .scl_phy_data_o(scl_phy_data_o), .scl_sel_od_pp_o(scl_sel_od_pp_o),
    .sda_phy_data_o(sda_phy_data_o), .sda_sel_od_pp_o(sda_sel_od_pp_o));

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] lines();
    return {scl_phy_data_o, scl_sel_od_pp_o, sda_phy_data_o, sda_sel_od_pp_o};
  endfunction

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  // Expected per-cycle picture: {scl data, scl sel, sda data, sda sel} plus handshake/status.
  typedef struct { logic [3:0] ln; logic rdy, bsy, rv, rb, er; } exp_t;
  exp_t exp_q[$];

  // Model: whether the bus is idle, and what SDA drive is held between bits.
  logic       m_idle = 1'b1;
  logic [1:0] m_sda  = 2'b00;

  task automatic push(input logic [3:0] ln, input logic rdy, bsy, rv, rb, er);
    exp_t e;
    e.ln = ln; e.rdy = rdy; e.bsy = bsy; e.rv = rv; e.rb = rb; e.er = er;
    exp_q.push_back(e);
  endtask

  task automatic build(input logic [1:0] op, input logic b, pp, sda);
    int lo, hi, hd;
    logic [1:0] nd;
    lo = (t_low_i == 0) ? 1 : int'(t_low_i);
    hi = (t_high_i == 0) ? 1 : int'(t_high_i);
    hd = (int'(t_hd_i) >= lo) ? lo - 1 : int'(t_hd_i);
    exp_q.delete();
    if ((m_idle && op != 2'b01) || (!m_idle && op == 2'b11)) begin
      push(m_idle ? 4'b0000 : {2'b01, m_sda}, 1, !m_idle, 0, 0, 1);
    end else if (m_idle) begin
      for (int i = 0; i < hi; i++) push(4'b1110, 0, 1, 0, 0, 0);
      m_sda = 2'b10; m_idle = 1'b0;
      push({2'b01, m_sda}, 1, 1, 0, 0, 0);
    end else if (op == 2'b00) begin
      nd = pp ? {b, 1'b1} : {~b, 1'b0};
      for (int i = 0; i < lo; i++) push({2'b01, (i < hd) ? m_sda : nd}, 0, 1, 0, 0, 0);
      for (int i = 0; i < hi; i++) push({2'b11, nd}, 0, 1, 0, 0, 0);
      m_sda = nd;
      push({2'b01, m_sda}, 1, 1, 1, sda, 0);
    end else if (op == 2'b01) begin
      for (int i = 0; i < lo; i++) push(4'b0100, 0, 1, 0, 0, 0);
      for (int i = 0; i < hi; i++) push(4'b1100, 0, 1, 0, 0, 0);
      for (int i = 0; i < hi; i++) push(4'b1110, 0, 1, 0, 0, 0);
      m_sda = 2'b10;
      push({2'b01, m_sda}, 1, 1, 0, 0, 0);
    end else begin
      for (int i = 0; i < lo; i++) push(4'b0110, 0, 1, 0, 0, 0);
      for (int i = 0; i < hi; i++) push(4'b1110, 0, 1, 0, 0, 0);
      for (int i = 0; i < hi; i++) push(4'b1100, 0, 1, 0, 0, 0);
      m_idle = 1'b1; m_sda = 2'b00;
      push(4'b0000, 1, 0, 0, 0, 0);
    end
  endtask

  // Presents one request, checks every following cycle against the model, and
  // reports how long ready stayed low, the sampled response bit and any error.
  task automatic apply_req(input logic [1:0] op, input logic b, pp, sda,
                           output int dur, output logic rb, output logic er);
    build(op, b, pp, sda);
    req_op_i = op; req_bit_i = b; req_pp_i = pp; sda_i = sda; req_valid_i = 1'b1;
    chk("req_ready", req_ready_o, 1'b1);
    step();
    req_valid_i = 1'b0; req_bit_i = ~b; req_pp_i = ~pp; req_op_i = 2'($urandom);
    dur = -1; rb = 1'b0; er = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk("lines", lines(), exp_q[i].ln);
      chk("ready", req_ready_o, exp_q[i].rdy);
      chk("busy", busy_o, exp_q[i].bsy);
      chk("rsp_valid", rsp_valid_o, exp_q[i].rv);
      chk("err", err_o, exp_q[i].er);
      if (exp_q[i].rv) chk("rsp_bit", rsp_bit_o, exp_q[i].rb);
      if (dur < 0 && req_ready_o === 1'b1) dur = i;
      if (rsp_valid_o === 1'b1) rb = rsp_bit_o;
      if (err_o === 1'b1) er = 1'b1;
      if (i < exp_q.size() - 1) step();
    end
  endtask

  typedef struct {
    logic [1:0] op; logic b, pp, sda;
    logic [7:0] tl, th, thd;
    int dur; logic rb, er;
  } vec_t;

  initial begin
    vec_t tbl[13];
    int dur;
    logic rb, er;

    tbl[0]  = '{2'b01, 0, 0, 1, 8'd4, 8'd3, 8'd1,  3, 0, 0};  // START from IDLE
    tbl[1]  = '{2'b00, 1, 1, 1, 8'd4, 8'd3, 8'd1,  7, 1, 0};  // BIT 1 PP
    tbl[2]  = '{2'b00, 1, 0, 0, 8'd4, 8'd3, 8'd1,  7, 0, 0};  // BIT 1 OD, ACK low
    tbl[3]  = '{2'b00, 0, 1, 0, 8'd4, 8'd3, 8'd1,  7, 0, 0};  // BIT 0 PP
    tbl[4]  = '{2'b11, 0, 0, 1, 8'd4, 8'd3, 8'd1,  0, 0, 1};  // reserved op in HOLD
    tbl[5]  = '{2'b01, 0, 0, 1, 8'd4, 8'd3, 8'd1, 10, 0, 0};  // repeated START
    tbl[6]  = '{2'b10, 0, 0, 1, 8'd4, 8'd3, 8'd1, 10, 0, 0};  // STOP
    tbl[7]  = '{2'b00, 1, 1, 1, 8'd4, 8'd3, 8'd1,  0, 0, 1};  // BIT in IDLE
    tbl[8]  = '{2'b01, 0, 0, 1, 8'd0, 8'd3, 8'd1,  3, 0, 0};  // START, t_low=0
    tbl[9]  = '{2'b00, 0, 0, 1, 8'd0, 8'd3, 8'd1,  4, 1, 0};  // BIT, 1-cycle low
    tbl[10] = '{2'b00, 1, 1, 1, 8'd4, 8'd0, 8'd1,  5, 1, 0};  // BIT, t_high=0
    tbl[11] = '{2'b00, 1, 1, 0, 8'd4, 8'd3, 8'd9,  7, 0, 0};  // BIT, t_hd clamped
    tbl[12] = '{2'b10, 0, 0, 1, 8'd4, 8'd3, 8'd1, 10, 0, 0};  // STOP

    // Reset state
    #12;
    chk("rst_lines", lines(), 4'b0000);
    chk("rst_ready", req_ready_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_rsp_bit", rsp_bit_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    @(negedge clk_i); rst_i = 1'b0;
    step();
    chk("idle_ready", req_ready_o, 1'b1);

    // Directed vectors
    foreach (tbl[k]) begin
      t_low_i = tbl[k].tl; t_high_i = tbl[k].th; t_hd_i = tbl[k].thd;
      apply_req(tbl[k].op, tbl[k].b, tbl[k].pp, tbl[k].sda, dur, rb, er);
      chk($sformatf("vec%0d_dur", k), dur, tbl[k].dur);
      chk($sformatf("vec%0d_rsp_bit", k), rb, tbl[k].rb);
      chk($sformatf("vec%0d_err", k), er, tbl[k].er);
    end

    // Reset asserted in the middle of BIT_HIGH
    t_low_i = 8'd4; t_high_i = 8'd3; t_hd_i = 8'd1;
    apply_req(2'b01, 0, 0, 1, dur, rb, er);
    req_op_i = 2'b00; req_bit_i = 1'b1; req_pp_i = 1'b1; sda_i = 1'b1; req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    repeat (5) step();
    chk("pre_rst_scl_high", lines(), 4'b1111);
    #1 rst_i = 1'b1;
    #1;
    chk("midrst_lines", lines(), 4'b0000);
    chk("midrst_ready", req_ready_o, 1'b0);
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_rsp_valid", rsp_valid_o, 1'b0);
    repeat (3) begin
      step();
      chk("midrst_no_rsp", rsp_valid_o, 1'b0);
    end
    @(negedge clk_i); rst_i = 1'b0;
    step();
    chk("post_rst_ready", req_ready_o, 1'b1);
    chk("post_rst_busy", busy_o, 1'b0);
    chk("post_rst_lines", lines(), 4'b0000);
    m_idle = 1'b1; m_sda = 2'b00;

    // Random requests against the model
    for (int n = 0; n < 200; n++) begin
      logic [1:0] op;
      t_low_i  = 8'($urandom_range(0, 5));
      t_high_i = 8'($urandom_range(0, 4));
      t_hd_i   = 8'($urandom_range(0, 6));
      if (m_idle) op = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b01;
      else begin
        case ($urandom_range(0, 9))
          0:       op = 2'b01;
          1:       op = 2'b10;
          2:       op = 2'b11;
          default: op = 2'b00;
        endcase
      end
      apply_req(op, 1'($urandom), 1'($urandom), 1'($urandom), dur, rb, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
